// File: rtl/ula_pkg.sv
// ula_pkg: shared op and state encodings for the ula_issuer front-end
package ula_pkg;
   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_SHR = 2'd2,
      OP_SHL = 2'd3
   } op_e;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_e;
endpackage

// File: rtl/ula_issuer_dp.sv
// ula_issuer_dp: combinational (WIDTH+1)-bit ALU datapath producing {ovf, result}
module ula_issuer_dp
   import ula_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   res
);
   logic [WIDTH:0] ae, be;
   assign ae = {1'b0, a};
   assign be = {1'b0, b};
   // zero-extended operands make carry, borrow and shifted-out bit land in the top bit
   always_comb res = op == OP_ADD ? ae + be :
                     op == OP_SUB ? ae - be :
                     op == OP_SHR ? ae >> b : ae << b;
endmodule

// File: rtl/ula_issuer.sv
// ula_issuer: valid/ready front-end around the ALU datapath; ULA_ISSUER_CHAIN_EN enables result chaining
module ula_issuer
   import ula_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_sel,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_chain,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_ovf,
   output logic             busy,
   output logic [CNT_W-1:0] ovf_cnt
);
   state_e state, state_nx;
   op_e op_q;
   logic [WIDTH-1:0] a_q, b_q, a_in;
   logic [WIDTH:0] res, res_q;
   logic [CNT_W-1:0] cnt;
   logic acc, hs;
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb state_nx = state == IDLE ? (cmd_valid ? EXEC : IDLE) :
                          state == EXEC ? HOLD : (rsp_ready ? IDLE : HOLD);
   always_comb begin
      cmd_ready = state == IDLE;
      rsp_valid = state == HOLD;
      busy = state != IDLE;
   end
   assign acc = cmd_valid & cmd_ready;
   assign hs = rsp_valid & rsp_ready;
`ifdef ULA_ISSUER_CHAIN_EN
   logic [WIDTH-1:0] chain_q;
   always_ff @(posedge clk)
      if (rst) chain_q <= '0;
      else if (hs) chain_q <= res_q[WIDTH-1:0];
   assign a_in = cmd_chain ? chain_q : cmd_a;
`else
   logic unused_chain;
   assign unused_chain = cmd_chain;
   assign a_in = cmd_a;
`endif
   always_ff @(posedge clk)
      if (rst) begin
         op_q <= OP_ADD;
         a_q <= '0;
         b_q <= '0;
         res_q <= '0;
         cnt <= '0;
      end else begin
         if (acc) begin
            op_q <= op_e'(cmd_sel);
            a_q <= a_in;
            b_q <= cmd_b;
         end
         if (state == EXEC) res_q <= res;
         if (hs && res_q[WIDTH] && cnt != '1) cnt <= cnt + CNT_W'(1);
      end
   ula_issuer_dp #(.WIDTH(WIDTH)) u_dp (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .res(res)
   );
   assign rsp_data = res_q[WIDTH-1:0];
   assign rsp_ovf = res_q[WIDTH];
   assign ovf_cnt = cnt;
endmodule

// File: tb/tb_ula_issuer.sv
// tb_ula_issuer: vector table plus handshake corner cases, scoreboard queue checks every response
module tb_ula_issuer;
   logic clk = 0, rst = 1;
   logic cmd_valid = 0, cmd_ready, cmd_chain = 0;
   logic [1:0] cmd_sel = 0;
   logic [3:0] cmd_a = 0, cmd_b = 0;
   logic rsp_valid, rsp_ready = 1, rsp_ovf, busy;
   logic [3:0] rsp_data;
   logic [7:0] ovf_cnt;
   int n_chk = 0, n_fail = 0;
   int exp_cnt = 0;
   logic [4:0] exp_q[$];
   logic [4:0] e;
   typedef struct {
      logic [1:0] sel;
      logic [3:0] a, b, d;
      logic o;
   } vec_t;
   vec_t vt[12];

   ula_issuer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_ovf(rsp_ovf), .busy(busy), .ovf_cnt(ovf_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", n, act, exp);
      end
   endtask

   // scoreboard: every response handshake pops one expected {ovf, data}
   always @(negedge clk) begin
      if (rst) exp_cnt = 0;
      else if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e[3:0]);
            chk("rsp_ovf", rsp_ovf, e[4]);
            if (e[4] && exp_cnt != 255) exp_cnt++;
         end
      end
   end

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("drain_timeout", k < 50, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b,
                         input logic ch, input logic [3:0] ed, input logic eo);
      int k = 0;
      cmd_sel = s; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_valid = 1;
      exp_q.push_back({eo, ed});
      @(negedge clk);
      while (!cmd_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("accept_timeout", k < 50, 1);
      @(posedge clk);
      #1 cmd_valid = 0; cmd_chain = 0;
      @(negedge clk);
      chk("exec_cmd_ready", cmd_ready, 0);
      chk("exec_rsp_valid", rsp_valid, 0);
      chk("exec_busy", busy, 1);
      @(negedge clk);
      chk("latency_rsp_valid", rsp_valid, 1);
      drain();
   endtask

   initial begin
      vt[0]  = '{2'd0, 4'h9, 4'h8, 4'h1, 1'b1};
      vt[1]  = '{2'd1, 4'h3, 4'h5, 4'hE, 1'b1};
      vt[2]  = '{2'd1, 4'h5, 4'h3, 4'h2, 1'b0};
      vt[3]  = '{2'd3, 4'hB, 4'h1, 4'h6, 1'b1};
      vt[4]  = '{2'd2, 4'hB, 4'h2, 4'h2, 1'b0};
      vt[5]  = '{2'd3, 4'hF, 4'h7, 4'h0, 1'b0};
      vt[6]  = '{2'd0, 4'h3, 4'h4, 4'h7, 1'b0};
      vt[7]  = '{2'd2, 4'hF, 4'h5, 4'h0, 1'b0};
      vt[8]  = '{2'd3, 4'h1, 4'h4, 4'h0, 1'b1};
      vt[9]  = '{2'd2, 4'h8, 4'h4, 4'h0, 1'b0};
      vt[10] = '{2'd0, 4'hF, 4'h1, 4'h0, 1'b1};
      vt[11] = '{2'd1, 4'h0, 4'h1, 4'hF, 1'b1};

      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_rsp_ovf", rsp_ovf, 0);
      chk("reset_busy", busy, 0);
      chk("reset_ovf_cnt", ovf_cnt, 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         run_op(vt[i].sel, vt[i].a, vt[i].b, 1'b0, vt[i].d, vt[i].o);
         chk("ovf_cnt_vec", ovf_cnt, exp_cnt);
      end
      chk("ovf_cnt_after_table", ovf_cnt, 6);

      // backpressure with a second request waiting
      rsp_ready = 0;
      cmd_sel = 2'd0; cmd_a = 4'hF; cmd_b = 4'hF; cmd_valid = 1;
      exp_q.push_back({1'b1, 4'hE});
      @(posedge clk);
      #1 cmd_sel = 2'd1; cmd_a = 4'h5; cmd_b = 4'h3;
      exp_q.push_back({1'b0, 4'h2});
      @(negedge clk);
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold_valid", rsp_valid, 1);
         chk("bp_hold_data", rsp_data, 4'hE);
         chk("bp_hold_ovf", rsp_ovf, 1);
         chk("bp_cmd_ready", cmd_ready, 0);
      end
      @(posedge clk);
      #1 rsp_ready = 1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_second_ready", cmd_ready, 1);
      chk("bp_second_busy", busy, 0);
      @(posedge clk);
      #1 cmd_valid = 0;
      @(negedge clk);
      chk("bp_second_accepted", cmd_ready, 0);
      drain();
      chk("bp_ovf_cnt", ovf_cnt, 7);

      // chaining: second add takes the delivered 9 as operand a when enabled
      run_op(2'd0, 4'h7, 4'h2, 1'b0, 4'h9, 1'b0);
`ifdef ULA_ISSUER_CHAIN_EN
      run_op(2'd0, 4'h0, 4'h3, 1'b1, 4'hC, 1'b0);
`else
      run_op(2'd0, 4'h0, 4'h3, 1'b1, 4'h3, 1'b0);
`endif

      // saturation of the overflow counter
      repeat (252) run_op(2'd0, 4'hF, 4'hF, 1'b0, 4'hE, 1'b1);
      chk("ovf_cnt_sat_model", ovf_cnt, exp_cnt);
      chk("ovf_cnt_sat", ovf_cnt, 8'hFF);

      // reset during EXEC drops the op
      cmd_sel = 2'd0; cmd_a = 4'h1; cmd_b = 4'h1; cmd_valid = 1;
      @(posedge clk);
      #1 cmd_valid = 0; rst = 1;
      @(negedge clk);
      chk("rst_in_exec_busy", busy, 1);
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_ovf_cnt", ovf_cnt, 0);
      repeat (6) begin
         @(negedge clk);
         chk("rst_no_rsp", rsp_valid, 0);
      end
      @(posedge clk);
      #1;
`ifdef ULA_ISSUER_CHAIN_EN
      run_op(2'd0, 4'h5, 4'h3, 1'b1, 4'h3, 1'b0);
`else
      run_op(2'd0, 4'h5, 4'h3, 1'b1, 4'h8, 1'b0);
`endif
      run_op(2'd0, 4'h9, 4'h8, 1'b0, 4'h1, 1'b1);
      chk("post_rst_ovf_cnt", ovf_cnt, 1);
      chk("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
